// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, NOP encoding, fault codes.
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] LEGV8_NOP = 32'hD503201F;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;

endpackage

// File: rtl/instruction_fetch_unit_timeout.sv
// Saturating wait counter for an outstanding memory request; flags the last allowed cycle.
module fetch_timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    assign expired = (count == LAST);

    // Count cycles spent waiting; hold at the last value instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: reads one instruction per PC over a req/ack memory port and hands it
// to decode with valid/ready. Misaligned PCs and memory timeouts yield a faulting NOP.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32,
    parameter int TIMEOUT = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic               fetch_en,
    input  logic               flush,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               instr_fault,
    output logic [1:0]         fault_code,
    output logic               pc_advance
);

    fetch_state_t state;
    logic [ADDR_W-1:0] fetch_addr;
    logic cnt_clear;
    logic expired;

    // A new aligned fetch starts a fresh wait window.
    assign cnt_clear = (state == S_IDLE) && fetch_en && !flush && (pc_in[1:0] == 2'b00);

    fetch_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (cnt_clear),
        .en      (imem_req),
        .expired (expired)
    );

    assign imem_addr  = fetch_addr;
    // PC may only move when decode takes the instruction and no redirect is in flight.
    assign pc_advance = instr_valid && instr_ready && !flush;

    // Fetch FSM with registered request and instruction outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            fetch_addr  <= '0;
            imem_req    <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            instr_fault <= 1'b0;
            fault_code  <= FC_NONE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fetch_en && !flush) begin
                        fetch_addr <= pc_in;
                        if (pc_in[1:0] != 2'b00) begin
                            // Misaligned: skip memory entirely and present a faulting NOP.
                            state       <= S_HOLD;
                            instr       <= INSTR_W'(LEGV8_NOP);
                            instr_pc    <= pc_in;
                            instr_valid <= 1'b1;
                            instr_fault <= 1'b1;
                            fault_code  <= FC_MISALIGN;
                        end else begin
                            state    <= S_REQ;
                            imem_req <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        if (!flush) begin
                            state       <= S_HOLD;
                            instr       <= imem_rdata;
                            instr_pc    <= fetch_addr;
                            instr_valid <= 1'b1;
                            instr_fault <= 1'b0;
                            fault_code  <= FC_NONE;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (flush) begin
                        // Request cannot be retracted; keep it up until the memory answers.
                        state <= S_DISCARD;
                    end else if (expired) begin
                        state       <= S_HOLD;
                        imem_req    <= 1'b0;
                        instr       <= INSTR_W'(LEGV8_NOP);
                        instr_pc    <= fetch_addr;
                        instr_valid <= 1'b1;
                        instr_fault <= 1'b1;
                        fault_code  <= FC_TIMEOUT;
                    end
                end
                S_HOLD: begin
                    // Flush wins over ready; either way the instruction leaves.
                    if (flush || instr_ready) begin
                        state       <= S_IDLE;
                        instr_valid <= 1'b0;
                    end
                end
                S_DISCARD: begin
                    if (imem_ack || expired) begin
                        state    <= S_IDLE;
                        imem_req <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
